// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared types and helpers for fifo_wr_arbiter; FIFO_WR_ARB_TAG_EN widens the FIFO word with the source index
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

`ifdef FIFO_WR_ARB_TAG_EN
    localparam bit ARB_TAG_EN = 1'b1;
`else
    localparam bit ARB_TAG_EN = 1'b0;
`endif

    function automatic int arb_idx_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int arb_out_w(input int dw, input int iw, input bit tag);
        return tag ? dw + iw : dw;
    endfunction

    // Reference round-robin search: first set bit of req starting after ptr, modulo n; returns {found, idx}
    function automatic logic [MAX_IDX_W:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [MAX_IDX_W-1:0] ptr, input int n);
        logic [MAX_IDX_W:0] r;
        int k;
        r = '0;
        for (int i = n; i >= 1; i--) begin
            k = (int'(ptr) + i) % n;
            if (req[k]) r = {1'b1, MAX_IDX_W'(k)};
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// rr_prio_picker: combinational round-robin pick by rotate, priority-encode and rotate-back
module rr_prio_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    int             start;

    // Rotate so the slot after ptr sits at bit 0, take the lowest set bit, then map back
    always_comb begin
        start = (int'(ptr) + 1) % N;
        dbl   = {req, req} >> start;
        rot   = dbl[N-1:0];
        found = |rot;
        off   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = IW'(i);
        idx   = IW'((int'(off) + start) % N);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin packet-locking arbiter feeding one registered FIFO write stage; FIFO_WR_ARB_TAG_EN prepends the source index to each word
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    localparam int IDX_W      = arb_idx_w(NUM_REQ),
    localparam int OUT_W      = arb_out_w(DATA_WIDTH, IDX_W, ARB_TAG_EN)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ack_o,
    output logic                          fifo_we_o,
    output logic [OUT_W-1:0]              fifo_din_o,
    input  logic                          fifo_wrdy_i,
    output logic [IDX_W-1:0]              owner_o,
    output logic                          locked_o
);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        owner_q, win_idx, sel;
    logic                    win_found, stage_rdy, go, we_q;
    logic [OUT_W-1:0]        din_q, word;
    logic [DATA_WIDTH-1:0]   sel_data;

    rr_prio_picker #(.N(NUM_REQ), .IW(IDX_W)) u_picker (
        .req   (req_i),
        .ptr   (owner_q),
        .found (win_found),
        .idx   (win_idx)
    );

    assign stage_rdy = ~we_q | fifo_wrdy_i;

    // Pick the requester to serve, decide whether its word is taken, and where the lock goes next
    always_comb begin
        sel       = (state_q == ARB_IDLE) ? win_idx : owner_q;
        go        = ~rst_i & stage_rdy & ((state_q == ARB_IDLE) ? win_found : req_i[owner_q]);
        req_ack_o = go ? (NUM_REQ'(1) << sel) : '0;
        state_d   = go ? (req_last_i[sel] ? ARB_IDLE : ARB_LOCKED) : state_q;
        sel_data  = req_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
`ifdef FIFO_WR_ARB_TAG_EN
        word      = {sel, sel_data};
`else
        word      = sel_data;
`endif
    end

    // Lock state, round-robin pointer and the output stage; a new word may replace one draining this cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            owner_q <= IDX_W'(NUM_REQ - 1);
            we_q    <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            if (go) begin
                owner_q <= sel;
                we_q    <= 1'b1;
                din_q   <= word;
            end else if (fifo_wrdy_i) begin
                we_q    <= 1'b0;
            end
        end
    end

    assign fifo_we_o  = we_q;
    assign fifo_din_o = din_q;
    assign owner_o    = owner_q;
    assign locked_o   = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter against a cycle-level behavioural model
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int IW = 2;
`ifdef FIFO_WR_ARB_TAG_EN
    localparam int OW = DW + IW;
`else
    localparam int OW = DW;
`endif

    logic            clk = 1'b0, rst = 1'b1, wrdy = 1'b1;
    logic [N-1:0]    req = '0, last = '0, ack;
    logic [N*DW-1:0] data = '0;
    logic            we, locked;
    logic [OW-1:0]   din;
    logic [IW-1:0]   owner;

    int n_chk = 0, n_fail = 0;

    int            m_owner = N - 1;
    bit            m_locked = 1'b0, m_we = 1'b0;
    logic [OW-1:0] m_din = '0;
    logic [N-1:0]  m_ack = '0, got_ack = '0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .req_last_i  (last),
        .req_data_i  (data),
        .req_ack_o   (ack),
        .fifo_we_o   (we),
        .fifo_din_o  (din),
        .fifo_wrdy_i (wrdy),
        .owner_o     (owner),
        .locked_o    (locked)
    );

    function automatic logic [OW-1:0] mk_word(input int k, input logic [DW-1:0] d);
`ifdef FIFO_WR_ARB_TAG_EN
        return {IW'(k), d};
`else
        return d;
`endif
    endfunction

    // Drive one cycle of inputs, sample the ack, clock, and advance the model
    task automatic cyc(input logic rs, input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*DW-1:0] d, input logic w);
        int k = -1;
        rst = rs; req = r; last = l; data = d; wrdy = w;
        #1;
        if (!rs && (!m_we || w)) begin
            if (m_locked) begin
                if (r[m_owner]) k = m_owner;
            end else begin
                for (int i = N; i >= 1; i--)
                    if (r[(m_owner + i) % N]) k = (m_owner + i) % N;
            end
        end
        m_ack = (k >= 0) ? (N'(1) << k) : '0;
        got_ack = ack;
        @(posedge clk);
        #1;
        if (rs) begin
            m_owner = N - 1; m_locked = 1'b0; m_we = 1'b0; m_din = '0;
        end else if (k >= 0) begin
            m_we = 1'b1; m_din = mk_word(k, d[k*DW +: DW]); m_owner = k; m_locked = !l[k];
        end else if (w) begin
            m_we = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, '1, '1, $urandom, 1'b1);
            n_chk++;
            if (got_ack !== '0 || we !== 1'b0 || din !== '0 || owner !== IW'(N - 1) || locked !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got ack=%b we=%b din=%h owner=%0d locked=%b, want 0 0 0 %0d 0", i, got_ack, we, din, owner, locked, N - 1);
            end
        end
    endtask

    task automatic test_single_stream();
        cyc(1'b1, '0, '0, '0, 1'b1);
        for (int j = 0; j < 6; j++) begin
            if (j < 4) cyc(1'b0, 4'b0001, (j == 3) ? 4'b0001 : 4'b0000, {24'h0, 8'h11 + 8'(j)}, 1'b1);
            else       cyc(1'b0, '0, '0, '0, 1'b1);
            n_chk++;
            if (got_ack !== m_ack || we !== m_we || din !== m_din || owner !== IW'(m_owner) || locked !== m_locked) begin
                n_fail++;
                $display("FAIL single_model[%0d]: got ack=%b we=%b din=%h owner=%0d locked=%b, want ack=%b we=%b din=%h owner=%0d locked=%b", j, got_ack, we, din, owner, locked, m_ack, m_we, m_din, m_owner, m_locked);
            end
            n_chk++;
            if (j < 4 && (got_ack !== 4'b0001 || we !== 1'b1 || din !== mk_word(0, 8'h11 + 8'(j)) || locked !== (j < 3))) begin
                n_fail++;
                $display("FAIL single[%0d]: got ack=%b we=%b din=%h locked=%b, want ack=0001 we=1 din=%h locked=%b", j, got_ack, we, din, locked, mk_word(0, 8'h11 + 8'(j)), j < 3);
            end else if (j >= 4 && (got_ack !== '0 || we !== 1'b0 || locked !== 1'b0)) begin
                n_fail++;
                $display("FAIL single_drain[%0d]: got ack=%b we=%b locked=%b, want 0 0 0", j, got_ack, we, locked);
            end
        end
    endtask

    task automatic test_round_robin();
        cyc(1'b1, '0, '0, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, '1, '1, $urandom, 1'b1);
            n_chk++;
            if (got_ack !== (N'(1) << (i % N)) || owner !== IW'(i % N) || locked !== 1'b0 || din !== m_din) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got ack=%b owner=%0d locked=%b din=%h, want ack=%b owner=%0d locked=0 din=%h", i, got_ack, owner, locked, din, N'(1) << (i % N), i % N, m_din);
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [N-1:0] v0[6]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        logic [N-1:0] exp[6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0100};
        cyc(1'b1, '0, '0, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 4'b0100 | v0[i], (i == 4) ? 4'b0101 : 4'b0100, $urandom, 1'b1);
            n_chk++;
            if (got_ack !== exp[i] || locked !== (i < 4) || we !== m_we || din !== m_din) begin
                n_fail++;
                $display("FAIL packet_lock[%0d]: got ack=%b locked=%b we=%b din=%h, want ack=%b locked=%b we=%b din=%h", i, got_ack, locked, we, din, exp[i], i < 4, m_we, m_din);
            end
        end
    endtask

    task automatic test_backpressure();
        cyc(1'b1, '0, '0, '0, 1'b1);
        cyc(1'b0, 4'b0010, 4'b0010, 32'h0000_5A00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 4'b0010, 4'b0010, 32'h0000_6B00, 1'b0);
            n_chk++;
            if (got_ack !== '0 || we !== 1'b1 || din !== mk_word(1, 8'h5A)) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got ack=%b we=%b din=%h, want ack=0000 we=1 din=%h", i, got_ack, we, din, mk_word(1, 8'h5A));
            end
        end
        cyc(1'b0, 4'b0010, 4'b0010, 32'h0000_6B00, 1'b1);
        n_chk++;
        if (got_ack !== 4'b0010 || we !== 1'b1 || din !== mk_word(1, 8'h6B)) begin
            n_fail++;
            $display("FAIL backpressure_release: got ack=%b we=%b din=%h, want ack=0010 we=1 din=%h", got_ack, we, din, mk_word(1, 8'h6B));
        end
        cyc(1'b0, '0, '0, '0, 1'b1);
        n_chk++;
        if (we !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_drain: got we=%b, want 0", we);
        end
    endtask

    task automatic test_reset_mid_packet();
        cyc(1'b1, '0, '0, '0, 1'b1);
        cyc(1'b0, 4'b0010, 4'b0000, 32'h0000_2100, 1'b1);
        cyc(1'b0, 4'b0010, 4'b0000, 32'h0000_2200, 1'b1);
        n_chk++;
        if (locked !== 1'b1 || owner !== 2'd1 || din !== mk_word(1, 8'h22)) begin
            n_fail++;
            $display("FAIL midpkt_pre: got locked=%b owner=%0d din=%h, want 1 1 %h", locked, owner, din, mk_word(1, 8'h22));
        end
        cyc(1'b1, 4'b0010, 4'b0000, 32'h0000_2300, 1'b1);
        n_chk++;
        if (got_ack !== '0 || we !== 1'b0 || locked !== 1'b0 || owner !== IW'(N - 1)) begin
            n_fail++;
            $display("FAIL midpkt_reset: got ack=%b we=%b locked=%b owner=%0d, want 0000 0 0 %0d", got_ack, we, locked, owner, N - 1);
        end
        cyc(1'b0, 4'b0011, 4'b0011, 32'h0000_3130, 1'b1);
        n_chk++;
        if (got_ack !== 4'b0001 || we !== 1'b1 || din !== mk_word(0, 8'h30) || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL midpkt_after: got ack=%b we=%b din=%h owner=%0d, want 0001 1 %h 0", got_ack, we, din, owner, mk_word(0, 8'h30));
        end
    endtask

    task automatic test_tag();
`ifdef FIFO_WR_ARB_TAG_EN
        logic [OW-1:0] exp = 10'h3A5;
`else
        logic [OW-1:0] exp = 8'hA5;
`endif
        cyc(1'b1, '0, '0, '0, 1'b1);
        cyc(1'b0, 4'b1000, 4'b1000, 32'hA500_0000, 1'b1);
        n_chk++;
        if (got_ack !== 4'b1000 || we !== 1'b1 || din !== exp) begin
            n_fail++;
            $display("FAIL tag: got ack=%b we=%b din=%h, want ack=1000 we=1 din=%h", got_ack, we, din, exp);
        end
    endtask

    task automatic test_random();
        cyc(1'b1, '0, '0, '0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 199) == 0, N'($urandom), N'($urandom & $urandom), $urandom, $urandom_range(0, 3) != 0);
            n_chk++;
            if (got_ack !== m_ack || we !== m_we || din !== m_din || owner !== IW'(m_owner) || locked !== m_locked) begin
                n_fail++;
                $display("FAIL random[%0d]: got ack=%b we=%b din=%h owner=%0d locked=%b, want ack=%b we=%b din=%h owner=%0d locked=%b", i, got_ack, we, din, owner, locked, m_ack, m_we, m_din, m_owner, m_locked);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_tag();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
